// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundles the hazard-controller signals between the pipeline datapath and
//   pipe_hazard_ctrl.
//   master: datapath side. Drives the hazard inputs and receives the stall/flush controls.
//   slave : controller side. Receives the hazard inputs and drives the controls.
//   Inputs : rsD, rtD, writeregE, MemtoRegE, div_startE, div_readyE,
//            memenM, data_okM, exceptM
//   Outputs: stallF/D/E/M, flushD/E/M/W, div_cancel, stall_cnt
interface pipe_hazard_ctrl_if #(
  parameter int unsigned RW    = 5,
  parameter int unsigned CNT_W = 32
);
  logic [RW-1:0]    rsD;
  logic [RW-1:0]    rtD;
  logic [RW-1:0]    writeregE;
  logic             MemtoRegE;
  logic             div_startE;
  logic             div_readyE;
  logic             memenM;
  logic             data_okM;
  logic             exceptM;

  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             stallM;
  logic             flushD;
  logic             flushE;
  logic             flushM;
  logic             flushW;
  logic             div_cancel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rsD, rtD, writeregE, MemtoRegE, div_startE, div_readyE, memenM, data_okM, exceptM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, div_cancel, stall_cnt
  );

  modport slave (
    input  rsD, rtD, writeregE, MemtoRegE, div_startE, div_readyE, memenM, data_okM, exceptM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, div_cancel, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage F/D/E/M/W pipeline. It resolves
//   hazards in this priority order: exception redirect, data-memory wait,
//   multi-cycle divide, then load-use.
//   Ports:
//     clk   - pipeline clock
//     reset - asynchronous, active-high reset
//     bus   - pipe_hazard_ctrl_if.slave (hazard inputs, stall/flush/cancel outputs)
//   Optional feature: define STALL_CNT_EN to get a free-running count of the
//   cycles in which stallF is asserted. Without the macro, stall_cnt is tied to 0.
module pipe_hazard_ctrl #(
  parameter int unsigned RW    = 5,
  parameter int unsigned CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [RW-1:0] RegZero = '0;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMemWait = 2'd1,
    StDivWait = 2'd2
  } state_e;

  state_e stateQ, stateD;

  logic stallF, stallD, stallE, stallM;
  logic flushD, flushE, flushM, flushW;
  logic divCancel;
  logic loadUse;
  logic memWait;

  // $0 is hard-wired to zero, so a load that targets it never creates a hazard.
  assign loadUse = bus.MemtoRegE && (bus.writeregE != RegZero) &&
                   ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD));
  assign memWait = bus.memenM && !bus.data_okM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    flushW    = 1'b0;
    divCancel = 1'b0;

    if (reset) begin
      // Release every stall as soon as reset is asserted, not at the next edge.
      stateD = StIdle;
    end else if (bus.exceptM) begin
      flushD    = 1'b1;
      flushE    = 1'b1;
      flushM    = 1'b1;
      flushW    = 1'b1;
      divCancel = (stateQ == StDivWait) || bus.div_startE;
      stateD    = StIdle;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (memWait) begin
            // The whole pipe freezes behind M; W is fed a bubble.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
            stateD = StMemWait;
          end else if (bus.div_startE) begin
            // The divide holds E, and M receives a bubble while it runs.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
            stateD = StDivWait;
          end else if (loadUse) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
          end
        end
        StMemWait: begin
          if (bus.data_okM) begin
            // If a divide is parked in E, it is picked up from StIdle on the next cycle.
            stateD = StIdle;
          end else begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
          end
        end
        StDivWait: begin
          if (bus.div_readyE) begin
            stateD = StIdle;
          end else begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
          end
        end
        default: begin
          stateD = StIdle;
        end
      endcase
    end
  end

  assign bus.stallF     = stallF;
  assign bus.stallD     = stallD;
  assign bus.stallE     = stallE;
  assign bus.stallM     = stallM;
  assign bus.flushD     = flushD;
  assign bus.flushE     = flushE;
  assign bus.flushM     = flushM;
  assign bus.flushW     = flushW;
  assign bus.div_cancel = divCancel;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cntQ;

  // Wraps naturally at 2^CNT_W. Only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cntQ <= '0;
    end else if (stallF) begin
      cntQ <= cntQ + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_cnt = cntQ;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (F/D/E/M/W).
- Drives the enable (~stall) and synchronous-clear (flush) inputs of every inter-stage register, including the E/M register.
- Resolves, in priority order: exception redirect, data-memory wait, multi-cycle divide, load-use hazard.
- Holds a small FSM for the multi-cycle cases so the stall timing is deterministic.

Parameters:
- RW, 5, register-specifier width.
- CNT_W, 32, stall-counter width (used only with STALL_CNT_EN).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- rsD  in  RW  source reg rs of instruction in D
- rtD  in  RW  source reg rt of instruction in D
- writeregE  in  RW  destination reg of instruction in E
- MemtoRegE  in  1  instruction in E is a load
- div_startE  in  1  div/divu present in E, needs the divider
- div_readyE  in  1  divider result valid (1-cycle pulse)
- memenM  in  1  data-memory access in M
- data_okM  in  1  data-memory handshake done this cycle
- exceptM  in  1  qualified exception/eret taken in M
- stallF, stallD, stallE, stallM  out  1 each  hold stage register
- flushD, flushE, flushM, flushW  out  1 each  clear stage register
- div_cancel  out  1  abort in-flight divide
- stall_cnt  out  CNT_W  stall-cycle count (STALL_CNT_EN only)

Behaviour:
- FSM states: IDLE, MEM_WAIT, DIV_WAIT. State is registered; all outputs are combinational from state and inputs.
- Reset: state=IDLE, stall_cnt=0. With quiescent inputs, all stall/flush/div_cancel = 0. Asynchronous reset mid-wait returns to IDLE immediately and releases all stalls.
- Exception (highest priority), any state, exceptM=1:
  - flushD, flushE, flushM, flushW = 1; all stalls = 0.
  - div_cancel = 1 if state==DIV_WAIT or div_startE=1.
  - Next state = IDLE.
- MEM_WAIT entry/hold:
  - In IDLE with memenM=1 & data_okM=0: stallF/D/E/M = 1, flushW = 1, next state MEM_WAIT.
  - In MEM_WAIT the same outputs hold until data_okM=1. That cycle: no stall, no flush, next state IDLE.
  - memenM=1 & data_okM=1 in IDLE: zero-cycle access, no stall.
- DIV_WAIT entry/hold:
  - In IDLE with div_startE=1 and no memory wait: stallF/D/E = 1, flushM = 1 (bubble into M), next state DIV_WAIT.
  - In DIV_WAIT the same outputs hold until div_readyE=1. That cycle: stalls release, flushM=0, next state IDLE.
  - div_readyE outside DIV_WAIT is ignored.
- Memory wait while E holds a divide: MEM_WAIT wins. Divide entry is deferred to IDLE; E is stalled anyway, so div_startE stays high.
- Load-use (lowest priority, IDLE only):
  - Condition: MemtoRegE=1 & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
  - Response: stallF = stallD = 1, flushE = 1 for exactly that cycle. No state change.
- Register $0 never creates a hazard.
- A stalled stage is never flushed in the same cycle, except under exceptM.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined: stall_cnt increments by 1 every cycle in which stallF=1. Wraps at 2^CNT_W−1 → 0. Cleared only by reset.
- Undefined: port stall_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Load-use: E = lw to $8 (writeregE=8, MemtoRegE=1), D has rsD=8 → one cycle of stallF=stallD=flushE=1, then all 0. Repeat with writeregE=0 → no stall.
- Memory wait: memenM=1, data_okM=0 for 3 cycles, then 1 → stallF/D/E/M=1 and flushW=1 for 3 cycles; state MEM_WAIT→IDLE; 4th cycle outputs 0.
- Divide: div_startE=1, div_readyE pulse after 33 cycles → stallF/D/E=1 and flushM=1 for 33 cycles; 0 on the ready cycle; state returns to IDLE.
- Exception during DIV_WAIT at cycle 10 → flushD/E/M/W=1 and div_cancel=1 that cycle; stalls 0; next cycle IDLE; later div_readyE pulse ignored.
- Collision: memenM=1/data_okM=0 with div_startE=1 for 2 cycles → MEM_WAIT first (stallM=1); after data_okM, DIV_WAIT entered next cycle.
- STALL_CNT_EN: scenarios 1–3 back-to-back → stall_cnt=37. Assert reset asynchronously mid-divide → stall_cnt=0, all stalls 0 before the next clk edge.
